// File: rtl/shift_chain_loader_pkg.sv
// Shared definitions for the host-driven configuration shift-chain loader.
// Covers the FSM state encoding and the protocol byte constants.
package shift_chain_loader_pkg;

  localparam int         BITS_PER_BYTE = 8;
  localparam logic [7:0] CMD_LOAD      = 8'h4C;
  localparam logic [7:0] ACK_CHAR      = 8'h4B;
  localparam logic [7:0] ECHO_DUMMY    = 8'h41;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LEN_LO    = 3'd1,
    ST_LEN_HI    = 3'd2,
    ST_DATA_WAIT = 3'd3,
    ST_SHIFT     = 3'd4,
    ST_ECHO      = 3'd5,
    ST_ACK       = 3'd6
  } state_t;

endpackage

// File: rtl/shift_chain_loader_shift_serializer.sv
// Serialises one byte into the chain LSB first while capturing the bits that fall out.
// With SHIFT_READBACK_EN undefined, no capture register is built and a dummy byte is returned.
module shift_chain_loader_shift_serializer
  import shift_chain_loader_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data_in,
  input  logic       start,
  input  logic       tail,
  output logic       head,
  output logic       enable,
  output logic       done,
  output logic [7:0] captured
);

  logic [7:0] r_sr;
  logic [2:0] r_bit_cnt;
  logic       r_enable;

  assign head   = r_sr[0];
  assign enable = r_enable;
  // done marks the last of the eight shift cycles, so the owner can leave SHIFT on that edge
  assign done   = r_enable && (r_bit_cnt == 3'(BITS_PER_BYTE - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sr      <= 8'h00;
      r_bit_cnt <= 3'd0;
      r_enable  <= 1'b0;
    end else begin
      if (load) begin
        r_sr      <= data_in;
        r_bit_cnt <= 3'd0;
      end else if (r_enable) begin
        r_sr      <= {1'b0, r_sr[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (start) begin
        r_enable <= 1'b1;
      end else if (done) begin
        r_enable <= 1'b0;
      end
    end
  end

`ifdef SHIFT_READBACK_EN
  logic [7:0] r_capture;

  // The tail bit seen during a shift cycle is the one present before that shift
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_capture <= 8'h00;
    end else if (r_enable) begin
      r_capture[r_bit_cnt] <= tail;
    end
  end

  assign captured = r_capture;
`else
  logic w_unused_tail;

  assign w_unused_tail = tail;
  assign captured      = ECHO_DUMMY;
`endif

endmodule

// File: rtl/shift_chain_loader.sv
// Host-driven loader: takes "L", a 16-bit length and payload bytes from the UART and shifts them into the chain.
// Each byte is echoed (captured tail byte with SHIFT_READBACK_EN, otherwise "A"), then "K" ends the load.
module shift_chain_loader
  import shift_chain_loader_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       shift_head,
  input  logic       shift_tail,
  output logic       shift_enable,
  output logic       busy,
  output logic       overrun
);

  state_t             r_state;
  logic [COUNT_W-1:0] r_count;
  logic [7:0]         r_len_lo;
  logic               r_out_valid;
  logic [7:0]         r_out_data;
  logic               r_busy;
  logic               r_overrun;

  logic               w_accept;
  logic               w_done;
  logic [7:0]         w_captured;
  logic [COUNT_W-1:0] w_len;
  logic [COUNT_W-1:0] w_count_dec;

  assign w_accept    = in_valid && (r_state == ST_DATA_WAIT);
  assign w_len       = COUNT_W'({in_data, r_len_lo});
  assign w_count_dec = (r_count == {COUNT_W{1'b0}}) ? {COUNT_W{1'b0}} : (r_count - COUNT_W'(1));

  shift_chain_loader_shift_serializer u_ser (
    .clock    (clock),
    .reset    (reset),
    .load     (w_accept),
    .data_in  (in_data),
    .start    (w_accept),
    .tail     (shift_tail),
    .head     (shift_head),
    .enable   (shift_enable),
    .done     (w_done),
    .captured (w_captured)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_count     <= {COUNT_W{1'b0}};
      r_len_lo    <= 8'h00;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (in_valid && (r_state inside {ST_SHIFT, ST_ECHO, ST_ACK})) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (in_valid && (in_data == CMD_LOAD)) begin
            r_state <= ST_LEN_LO;
            r_busy  <= 1'b1;
          end
        end
        ST_LEN_LO: begin
          if (in_valid) begin
            r_len_lo <= in_data;
            r_state  <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (in_valid) begin
            r_count <= w_len;
            r_state <= (w_len == {COUNT_W{1'b0}}) ? ST_ACK : ST_DATA_WAIT;
          end
        end
        ST_DATA_WAIT: begin
          if (in_valid) begin
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_done) begin
            r_state <= ST_ECHO;
          end
        end
        // Gating on r_out_valid keeps the echo and "K" strobes from landing on adjacent cycles
        ST_ECHO: begin
          if (ready && !r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_captured;
            r_count     <= w_count_dec;
            r_state     <= (w_count_dec == {COUNT_W{1'b0}}) ? ST_ACK : ST_DATA_WAIT;
          end
        end
        ST_ACK: begin
          if (ready && !r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_data  <= ACK_CHAR;
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_shift_chain_loader.sv
// Directed and randomized bench for shift_chain_loader against a 16-bit chain model.
// Expected echoes follow SHIFT_READBACK_EN: tail byte when defined, "A" otherwise.
module tb_shift_chain_loader;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       shift_head;
  logic       shift_tail;
  logic       shift_enable;
  logic       busy;
  logic       overrun;

  always #5 clock = ~clock;

  shift_chain_loader #(.COUNT_W(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .ready        (ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .shift_head   (shift_head),
    .shift_tail   (shift_tail),
    .shift_enable (shift_enable),
    .busy         (busy),
    .overrun      (overrun)
  );

  // 16-bit chain: head enters at the top, tail leaves from bit 0
  logic [15:0] chain;
  logic        chain_wr = 1'b0;
  logic [15:0] chain_wr_val = 16'h0000;
  assign shift_tail = chain[0];

  always @(posedge clock) begin
    if (chain_wr) chain <= chain_wr_val;
    else if (shift_enable) chain <= {shift_head, chain[15:1]};
  end

  logic [7:0] rx_q[$];
  int  n_shift = 0;
  int  n_ones = 0;
  int  n_back2back = 0;
  logic prev_ov = 1'b0;

  always @(negedge clock) begin
    if (out_valid === 1'b1) rx_q.push_back(out_data);
    if (out_valid === 1'b1 && prev_ov === 1'b1) n_back2back <= n_back2back + 1;
    prev_ov <= out_valid;
    if (shift_enable === 1'b1) begin
      n_shift <= n_shift + 1;
      if (shift_head === 1'b1) n_ones <= n_ones + 1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] payload[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick(1);
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic wait_rx(input string tag);
    int budget;
    budget = 200;
    while (rx_q.size() == 0 && budget > 0) begin
      tick(1);
      budget--;
    end
    check({tag, "_arrived"}, (rx_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  function automatic logic [7:0] pop_rx();
    if (rx_q.size() == 0) return 8'hxx;
    return rx_q.pop_front();
  endfunction

  function automatic logic [7:0] echo_of(input logic [15:0] ch);
`ifdef SHIFT_READBACK_EN
    return ch[7:0];
`else
    return 8'h41;
`endif
  endfunction

  // One complete load of `payload`, pacing each byte on its echo
  task automatic load_seq(input logic [15:0] preload, input int stall, input string tag);
    logic [15:0] model;
    logic [7:0]  exp_echo;
    int          len;
    int          shift0;
    len = payload.size();
    chain_wr_val = preload;
    chain_wr = 1'b1;
    tick(1);
    chain_wr = 1'b0;
    model  = preload;
    shift0 = n_shift;
    send(8'h4C);
    send(len[7:0]);
    send(len[15:8]);
    for (int i = 0; i < len; i++) begin
      exp_echo = echo_of(model);
      model = {payload[i], model[15:8]};
      if (stall > 0) ready = 1'b0;
      send(payload[i]);
      if (stall > 0) begin
        tick(stall);
        check({tag, "_held_rx"}, rx_q.size(), 32'd0);
        check({tag, "_held_ov"}, {31'd0, out_valid}, 32'd0);
        ready = 1'b1;
      end
      wait_rx({tag, "_echo"});
      check({tag, "_echo"}, {24'd0, pop_rx()}, {24'd0, exp_echo});
    end
    wait_rx({tag, "_ack"});
    check({tag, "_ack"}, {24'd0, pop_rx()}, 32'h4B);
    check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    tick(2);
    check({tag, "_extra_rx"}, rx_q.size(), 32'd0);
    check({tag, "_chain"}, {16'd0, chain}, {16'd0, model});
    check({tag, "_shifts"}, n_shift - shift0, 8 * len);
  endtask

  initial begin
    logic [15:0] model;
    logic [7:0]  exp_echo;
    int          ones0;
    int          len;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    ready    = 1'b1;
    chain_wr_val = 16'h0000;
    chain_wr = 1'b1;
    tick(3);
    chain_wr = 1'b0;
    reset = 1'b0;
    tick(2);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_shift_enable", {31'd0, shift_enable}, 32'd0);
    check("rst_shift_head", {31'd0, shift_head}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);

    // Non-load bytes in IDLE are ignored
    send(8'h12);
    send(8'h4B);
    tick(3);
    check("idle_ignore_busy", {31'd0, busy}, 32'd0);
    check("idle_ignore_overrun", {31'd0, overrun}, 32'd0);

    payload = {};
    load_seq(16'h1234, 0, "zero_len");

    payload = {};
    payload.push_back(8'h3C);
    payload.push_back(8'hA5);
    load_seq(16'hBEEF, 0, "two_byte");

    payload = {};
    payload.push_back(8'h5A);
    load_seq(16'h00C3, 30, "backpressure");

    payload = {};
    payload.push_back(8'hFF);
    ones0 = n_ones;
    load_seq(16'h0000, 0, "all_ones");
    check("all_ones_head", n_ones - ones0, 32'd8);

    for (int t = 0; t < 5; t++) begin
      payload = {};
      len = $urandom_range(1, 3);
      for (int k = 0; k < len; k++) payload.push_back(8'($urandom));
      load_seq(16'($urandom), $urandom_range(0, 25), "random");
    end

    check("pre_overrun", {31'd0, overrun}, 32'd0);
    chain_wr_val = 16'h6D21;
    chain_wr = 1'b1;
    tick(1);
    chain_wr = 1'b0;
    model = 16'h6D21;
    send(8'h4C);
    send(8'h01);
    send(8'h00);
    exp_echo = echo_of(model);
    model = {8'h96, model[15:8]};
    send(8'h96);
    send(8'h77);
    tick(1);
    check("overrun_set", {31'd0, overrun}, 32'd1);
    wait_rx("overrun_echo");
    check("overrun_echo", {24'd0, pop_rx()}, {24'd0, exp_echo});
    wait_rx("overrun_ack");
    check("overrun_ack", {24'd0, pop_rx()}, 32'h4B);
    tick(3);
    check("overrun_chain", {16'd0, chain}, {16'd0, model});
    check("overrun_sticky", {31'd0, overrun}, 32'd1);
    check("overrun_busy", {31'd0, busy}, 32'd0);

    // Reset asserted in the third shift cycle
    send(8'h4C);
    send(8'h01);
    send(8'h00);
    send(8'hC9);
    tick(2);
    check("midshift_enable", {31'd0, shift_enable}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("midrst_shift_enable", {31'd0, shift_enable}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_data", {24'd0, out_data}, 32'd0);
    check("midrst_overrun", {31'd0, overrun}, 32'd0);
    check("midrst_shift_head", {31'd0, shift_head}, 32'd0);
    tick(2);
    reset = 1'b0;
    tick(3);
    check("postrst_busy", {31'd0, busy}, 32'd0);
    check("postrst_enable", {31'd0, shift_enable}, 32'd0);

    payload = {};
    payload.push_back(8'h81);
    load_seq(16'hF00D, 0, "after_reset");

    check("no_back2back", n_back2back, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
